// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
// Definitions shared by the instruction fetch unit and the instruction
// decoder:
//   - 4-bit opcode map of the 8-bit instruction word (INST[7:4]); the low
//     nibble carries an immediate or an index address.
//   - State encoding of the fetch unit controller.
//   - A small helper that classifies controller states.
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

    // Opcode map (INST[7:4])
    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_LDI  = 4'b0001;
    localparam logic [3:0] OP_LDX  = 4'b0010;
    localparam logic [3:0] OP_STX  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SUBI = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_NOTI = 4'b1001;
    localparam logic [3:0] OP_OR   = 4'b1010;
    localparam logic [3:0] OP_ORI  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_ANDI = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_XORI = 4'b1111;

    // Fetch controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // The unit reports BUSY while it is fetching or draining its buffer.
    function automatic logic is_busy_state(input logic [1:0] st);
        return (st == ST_FETCH) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
// DEPTH x DATA_W synchronous FIFO used as the instruction prefetch buffer.
// The head word is held in its own register so data_o is a flop output and
// reads 0 after reset. Push and pop on the same edge are supported, also on
// a full FIFO (the popped slot is reused).
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous reset, active-high (empties the FIFO)
//   push_i   in   write data_i this edge (ignored when full without a pop)
//   pop_i    in   remove the head word this edge (ignored when empty)
//   data_i   in   word to write
//   data_o   out  head word (registered)
//   count_o  out  number of stored words
//   full_o   out  count_o == DEPTH (registered)
//   empty_o  out  count_o == 0 (registered)
// ---------------------------------------------------------------------------
module inst_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic [DATA_W-1:0]            data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  kept;
    logic [DATA_W-1:0] head_q, head_d;
    logic              full_q, empty_q;
    logic              push_ok, pop_ok;

    assign pop_ok  = pop_i && !empty_q;
    assign push_ok = push_i && (!full_q || pop_ok);

    // Words already stored that survive this edge's pop.
    assign kept = count_q - CNT_W'(pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = kept + CNT_W'(push_ok);
        head_d   = head_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        // Next head: an older stored word if one remains, otherwise the
        // word being written right now bypasses the array.
        if (kept != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push_ok) begin
            head_d = data_i;
        end
    end

    // Storage array: data only, no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    assign data_o  = head_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch unit. Holds the program counter, reads instruction words
// from program memory over a req/ack handshake (at most one outstanding
// request), buffers them in a DEPTH-entry prefetch FIFO and issues them to the
// decoder under valid/ready. A word whose opcode equals HALT_OP stops fetching
// and is not issued; HALTED rises once the buffer has drained.
//
// Ports:
//   CLK         in   clock, rising edge
//   RST         in   asynchronous reset, active-high
//   START       in   one-cycle pulse, start fetching at address 0
//   MEM_REQ     out  memory read request
//   MEM_ADDR    out  read address (= PC), stable while MEM_REQ=1
//   MEM_ACK     in   memory accepts request, MEM_DATA valid same cycle
//   MEM_DATA    in   instruction word from memory
//   INST        out  instruction to decoder ([7:4] opcode, [3:0] imm/index)
//   INST_VALID  out  INST holds a valid word
//   INST_READY  in   decoder consumes INST this cycle
//   PC          out  address of the next word to fetch
//   BUSY        out  controller in FETCH or DRAIN
//   HALTED      out  HALT reached and buffer empty
// ---------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter int         DEPTH   = 2,
    parameter logic [3:0] HALT_OP = OP_HALT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [7:0]        MEM_DATA,
    output logic [7:0]        INST,
    output logic              INST_VALID,
    input  logic              INST_READY,
    output logic [ADDR_W-1:0] PC,
    output logic              BUSY,
    output logic              HALTED
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic              inst_valid_q, inst_valid_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic              xfer;
    logic              halt_word;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  cnt_next;
    logic              free_next;
    logic              fifo_full;
    logic              fifo_empty;

    // Memory handshake completes on an edge with MEM_REQ and MEM_ACK high;
    // an ACK without a pending request is ignored.
    assign xfer      = mem_req_q && MEM_ACK;
    assign halt_word = (MEM_DATA[7:4] == HALT_OP);
    assign pop       = inst_valid_q && INST_READY && !fifo_empty;
    assign push      = xfer && !halt_word && (!fifo_full || pop);

    // Buffer occupancy after this edge decides whether we may keep
    // requesting and whether draining has finished.
    assign cnt_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign free_next = (cnt_next < CNT_W'(DEPTH));

    inst_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (MEM_DATA),
        .data_o  (INST),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mem_req_d = 1'b0;
        halted_d  = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    pc_d      = '0;
                    mem_req_d = free_next;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req_d = free_next;
                if (xfer) begin
                    pc_d = pc_q + 1'b1;
                    if (halt_word) begin
                        mem_req_d = 1'b0;
                        if (cnt_next == '0) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d  = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_next == '0) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
            end
            ST_HALT: begin
                if (START) begin
                    pc_d      = '0;
                    halted_d  = 1'b0;
                    mem_req_d = free_next;
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                halted_d = 1'b0;
            end
        endcase
        busy_d       = is_busy_state(state_d);
        inst_valid_d = (cnt_next != '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            mem_req_q    <= 1'b0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_req_q    <= mem_req_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
        end
    end

    assign MEM_REQ    = mem_req_q;
    assign MEM_ADDR   = pc_q;
    assign PC         = pc_q;
    assign INST_VALID = inst_valid_q;
    assign BUSY       = busy_q;
    assign HALTED     = halted_q;

endmodule
